ahb_slave_mem: RTL
==================

// Module: ahb_slave_mem
// PURPOSE
// - Single-slave AHB-Lite responder: a word-organised memory behind the AHB
//   slave port, the responder end of the AHB test interface.
// - Decodes address/data phases, applies byte-lane writes, returns read data,
//   inserts programmable wait states, and gives the two-cycle ERROR response.
// - Sits directly on the AHB bus signals as the DUT-side target for the AHB
//   driver and monitor agents.
// PARAMETERS
// ADDR_WIDTH   32  haddr width
// DATA_WIDTH   32  hrdata/hwdata width; only 32 is supported
// MEM_DEPTH   256  number of 32-bit words
// BASE_ADDR     0  byte address of word 0; must be 4-byte aligned
// WAIT_STATES   0  hreadyout-low cycles per OKAY data phase (0..15)
// PORTS
// hclk       in   1           bus clock; all logic on posedge
// hreset     in   1           synchronous reset, active-high
// hsel       in   1           slave select
// haddr      in   ADDR_WIDTH  byte address (address phase)
// htrans     in   2           IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
// hwrite     in   1           1=write, 0=read
// hsize      in   3           000=byte 001=half 010=word
// hburst     in   3           burst type; accepted and ignored
// hprot      in   4           protection; accepted and ignored
// hmastlock  in   1           locked transfer; accepted and ignored
// hwdata     in   DATA_WIDTH  write data (data phase)
// hreadyin   in   1           bus hready; previous transfer is complete
// hreadyout  out  1           slave ready; low = wait state
// hresp      out  1           0=OKAY, 1=ERROR
// hrdata     out  DATA_WIDTH  read data
// BEHAVIOUR
// - Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, pending transfer dropped.
//   Memory contents are not cleared.
// - Accepting a transfer: on posedge with hsel & hreadyin & htrans[1]=1, latch
//   haddr, hwrite and hsize. The following cycle is its data phase.
// - IDLE/BUSY, or hsel=0: no access. The next cycle is OKAY with zero wait
//   (hreadyout=1, hresp=0).
// - Error checks at the address phase, flagged ERROR:
//   * address outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH)
//   * hsize > 010
//   * misaligned: half with haddr[0]=1, or word with haddr[1:0]!=0
// - FSM: IDLE, WAIT, DATA, ERR1, ERR2.
//   * IDLE -> WAIT when an OKAY transfer is accepted and WAIT_STATES>0.
//   * IDLE -> DATA when an OKAY transfer is accepted and WAIT_STATES=0.
//   * IDLE -> ERR1 when an ERROR transfer is accepted.
//   * WAIT: hreadyout=0, hresp=0 for exactly WAIT_STATES cycles, then DATA.
//   * DATA: hreadyout=1, hresp=0. The transfer completes at this edge; a new
//     transfer may be accepted at the same edge (pipelined, back-to-back).
//   * ERR1: hreadyout=0, hresp=1, then ERR2.
//   * ERR2: hreadyout=1, hresp=1. Nothing is written; hrdata=0. A new
//     transfer may be accepted at this edge.
// - Write commit: at the posedge ending the DATA cycle, from hwdata.
//   * Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
//   * Unselected lanes are unchanged.
// - Read data: hrdata = full 32-bit word at the latched address during the
//   DATA cycle; 0 in every other cycle. The master selects lanes.
// - Read-after-write ordering: a read whose address phase coincides with the
//   completing data phase of a write to the same word returns the merged,
//   just-written value (forward when the read path is registered).
// - Word index = (addr - BASE_ADDR) >> 2. No wrap-around: the top word + 4 is
//   out of range and gives ERROR.
// - hreset asserted mid-transfer: the transfer is abandoned, no memory write
//   occurs, and outputs take reset values on the next edge.
// TESTING
// - Reset released, WAIT_STATES=0: write NONSEQ word 0x10 data 0xDEADBEEF,
//   then read 0x10 -> hrdata=0xDEADBEEF in the DATA cycle, hreadyout=1,
//   hresp=0.
// - Byte write 0x11 data 0x0000AB00 over word 0x10 holding 0xDEADBEEF; read
//   0x10 -> 0xDEADABEF.
// - Back-to-back write 0x20=0x12345678 then read 0x20 (address phases on
//   consecutive edges) -> read returns 0x12345678 with no extra cycle.
// - WAIT_STATES=2: read 0x04 -> hreadyout low 2 cycles, then high with data;
//   hreadyin held low by the bench during waits blocks new acceptance.
// - Read 0x400 (MEM_DEPTH=256), or word write at 0x02 -> hresp=1 with
//   hreadyout 0 then 1; memory unchanged; hrdata=0.
// - hreset pulsed during the WAIT of a write 0x08=0xCAFEF00D -> outputs
//   1/0/0 next cycle; a later read 0x08 shows the old value.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite single-slave memory responder: word-organised storage with
// little-endian byte-lane writes, programmable wait states and two-cycle ERROR.
module ahb_slave_mem #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hmastlock,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hreadyin,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int unsigned           IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   SPAN    = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);
    localparam logic [3:0]            WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH:0]   off_ext;
    logic                  in_range;
    logic                  misaligned;
    logic                  addr_err;
    logic                  ready_state;
    logic                  accept;
    logic                  unused_ok;

    // A borrow out of the extended subtraction lands above SPAN, so one
    // compare covers both the lower and upper bound.
    assign off_ext     = {1'b0, haddr} - {1'b0, BASE_ADDR};
    assign in_range    = off_ext < SPAN;
    assign misaligned  = ((hsize == 3'b001) && haddr[0]) ||
                         ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
    assign addr_err    = !in_range || (hsize > 3'b010) || misaligned;
    assign ready_state = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept      = hsel && hreadyin && htrans[1] && ready_state;
    assign unused_ok   = ^{hburst, hprot, hmastlock};

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            lane_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (accept) begin
                idx_q   <= off_ext[IDX_W+1:2];
                lane_q  <= haddr[1:0];
                size_q  <= hsize[1:0];
                write_q <= hwrite;
            end
        end
    end

    // Storage is deliberately not reset; a reset during DATA suppresses the write.
    always_ff @(posedge hclk) begin
        if (!hreset && (state == S_DATA) && write_q) begin
            case (size_q)
                2'b00:   mem[idx_q][{lane_q, 3'b000} +: 8]     <= hwdata[{lane_q, 3'b000} +: 8];
                2'b01:   mem[idx_q][{lane_q[1], 4'b0000} +: 16] <= hwdata[{lane_q[1], 4'b0000} +: 16];
                default: mem[idx_q]                             <= hwdata;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        case (state)
            S_WAIT: begin
                hreadyout = 1'b0;
                if (wait_cnt == WS_LAST) state_nxt = S_DATA;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_nxt = S_ERR2;
            end
            default: begin
                if (state == S_ERR2) hresp = 1'b1;
                if ((state == S_DATA) && !write_q) hrdata = mem[idx_q];
                state_nxt = S_IDLE;
                if (accept) begin
                    if (addr_err)             state_nxt = S_ERR1;
                    else if (WAIT_STATES > 0) state_nxt = S_WAIT;
                    else                      state_nxt = S_DATA;
                end
            end
        endcase
    end

endmodule
